// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the operand width legality check used at elaboration.
`ifndef SERIAL_ADD_PKG_SV
`define SERIAL_ADD_PKG_SV

`define SERIAL_ADD_CHECK_WIDTH(w) \
    if ((w) < 1 || (w) > serial_add_pkg::MAX_WIDTH) begin : g_width_check \
        $error("serial_add_ctrl: WIDTH must be in 1..32"); \
    end

package serial_add_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`endif

// File: rtl/fulladder.sv
// Single-bit full adder; the only datapath element of the serial adder.
module fulladder (
    output logic sum,
    output logic cout,
    input  logic x,
    input  logic y,
    input  logic cin
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full adder walks the operands
// LSB-first, the carry lives in a flop, and the result lands with a done pulse.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    `SERIAL_ADD_CHECK_WIDTH(WIDTH)

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    fulladder u_fa (
        .sum  (fa_sum),
        .cout (fa_cout),
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .cin  (carry)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // Result bits enter at the MSB so that after WIDTH shifts the LSB sits at bit 0.
    generate
        if (WIDTH == 1) begin : g_single
            assign r_next = fa_sum;
        end else begin : g_multi
            assign r_next = {fa_sum, r_sh[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)    state_next = ST_RUN;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE:               state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_RUN);
            done  <= (state_next == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_next;
                    carry <= fa_cout;
                    cnt   <= cnt + CNT_W'(1);
                    // Results are only touched on the final-bit edge so they stay stable otherwise.
                    if (last_bit) begin
                        sum  <= r_next;
                        cout <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic [7:0] a      = '0;
    logic [7:0] b      = '0;
    logic       cin    = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1 = 1'b0;
    logic [0:0] a1     = '0;
    logic [0:0] b1     = '0;
    logic       cin1   = 1'b0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    // One-cycle start, then operands are scrambled; counts busy cycles, watches result hold.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         input logic [7:0] hold_sum, input logic hold_cout,
                         output int busy_cnt, output int done_cnt, output int hold_err,
                         output logic [7:0] res_sum, output logic res_cout);
        @(negedge clk);
        start = 1'b1; a = av; b = bv; cin = cv;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        busy_cnt = 0; done_cnt = 0; hold_err = 0;
        res_sum = 'x; res_cout = 1'bx;
        for (int i = 0; i < 20 && done_cnt == 0; i++) begin
            if (busy) begin
                busy_cnt++;
                if (sum !== hold_sum || cout !== hold_cout) hold_err++;
            end
            if (done) begin
                done_cnt++;
                res_sum = sum; res_cout = cout;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (sum !== 8'h00) begin n_fails++; $display("[TB] FAIL reset_sum: got %h expected 00", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_cout: got %b expected 0", cout); end
        n_checks++; if (busy1 !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy1: got %b expected 0", busy1); end
        n_checks++; if (done1 !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_done1: got %b expected 0", done1); end
        n_checks++; if (sum1 !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_sum1: got %b expected 0", sum1); end
        n_checks++; if (cout1 !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_cout1: got %b expected 0", cout1); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [7:0] va [5] = '{8'h5A, 8'hFF, 8'hFF, 8'h00, 8'h80};
        logic [7:0] vb [5] = '{8'h3C, 8'h01, 8'hFF, 8'h00, 8'h80};
        logic       vc [5] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
        logic [7:0] es [5] = '{8'h96, 8'h00, 8'hFF, 8'h00, 8'h01};
        logic       ec [5] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
        logic [7:0] hs;
        logic       hc;
        logic [7:0] rs;
        logic       rc;
        int bc, dc, he;
        hs = 8'h00; hc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vc[i], hs, hc, bc, dc, he, rs, rc);
            n_checks++; if (dc !== 1) begin n_fails++; $display("[TB] FAIL vec%0d done_seen: got %0d expected 1", i, dc); end
            n_checks++; if (bc !== 8) begin n_fails++; $display("[TB] FAIL vec%0d busy_cycles: got %0d expected 8", i, bc); end
            n_checks++; if (he !== 0) begin n_fails++; $display("[TB] FAIL vec%0d result_hold: got %0d changed cycles expected 0", i, he); end
            n_checks++; if (rs !== es[i]) begin n_fails++; $display("[TB] FAIL vec%0d sum: got %h expected %h", i, rs, es[i]); end
            n_checks++; if (rc !== ec[i]) begin n_fails++; $display("[TB] FAIL vec%0d cout: got %b expected %b", i, rc, ec[i]); end
            @(negedge clk);
            n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("[TB] FAIL vec%0d pulse_end: got done=%b busy=%b expected 0/0", i, done, busy); end
            hs = es[i]; hc = ec[i];
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        @(negedge clk);
        start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
        @(negedge clk);
        a = 8'h11; b = 8'h22;
        dc = 0;
        for (int i = 0; i < 20 && dc == 0; i++) begin
            if (done) dc++; else @(negedge clk);
        end
        n_checks++; if (dc !== 1) begin n_fails++; $display("[TB] FAIL b2b_first_done: got %0d expected 1", dc); end
        n_checks++; if (sum !== 8'h96) begin n_fails++; $display("[TB] FAIL b2b_first_sum: got %h expected 96", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fails++; $display("[TB] FAIL b2b_first_cout: got %b expected 0", cout); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fails++; $display("[TB] FAIL b2b_idle_gap: got busy=%b done=%b expected 0/0", busy, done); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("[TB] FAIL b2b_second_accept: got %b expected 1", busy); end
        start = 1'b0;
        dc = 0;
        for (int i = 0; i < 20 && dc == 0; i++) begin
            if (done) dc++; else @(negedge clk);
        end
        n_checks++; if (dc !== 1) begin n_fails++; $display("[TB] FAIL b2b_second_done: got %0d expected 1", dc); end
        n_checks++; if (sum !== 8'h33) begin n_fails++; $display("[TB] FAIL b2b_second_sum: got %h expected 33", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fails++; $display("[TB] FAIL b2b_second_cout: got %b expected 0", cout); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int bc, dc, he;
        logic [7:0] rs;
        logic       rc;
        @(negedge clk);
        start = 1'b1; a = 8'h0F; b = 8'hF0; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_rst_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_rst_done: got %b expected 0", done); end
        n_checks++; if (sum !== 8'h00) begin n_fails++; $display("[TB] FAIL mid_rst_sum: got %h expected 00", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_rst_cout: got %b expected 0", cout); end
        dc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dc++;
        end
        n_checks++; if (dc !== 0) begin n_fails++; $display("[TB] FAIL mid_rst_no_done: got %0d pulses expected 0", dc); end
        rst_n = 1'b1;
        do_op(8'h12, 8'h34, 1'b1, 8'h00, 1'b0, bc, dc, he, rs, rc);
        n_checks++; if (dc !== 1) begin n_fails++; $display("[TB] FAIL post_rst_done: got %0d expected 1", dc); end
        n_checks++; if (bc !== 8) begin n_fails++; $display("[TB] FAIL post_rst_busy_cycles: got %0d expected 8", bc); end
        n_checks++; if (he !== 0) begin n_fails++; $display("[TB] FAIL post_rst_hold: got %0d expected 0", he); end
        n_checks++; if (rs !== 8'h47) begin n_fails++; $display("[TB] FAIL post_rst_sum: got %h expected 47", rs); end
        n_checks++; if (rc !== 1'b0) begin n_fails++; $display("[TB] FAIL post_rst_cout: got %b expected 0", rc); end
        @(negedge clk);
    endtask

    task automatic test_width1();
        logic va [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic vb [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic vc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic es [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic ec [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start1 = 1'b1; a1 = va[i]; b1 = vb[i]; cin1 = vc[i];
            @(negedge clk);
            start1 = 1'b0; a1 = ~va[i]; b1 = ~vb[i]; cin1 = ~vc[i];
            n_checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin n_fails++; $display("[TB] FAIL w1_%0d run: got busy=%b done=%b expected 1/0", i, busy1, done1); end
            @(negedge clk);
            n_checks++; if (busy1 !== 1'b0 || done1 !== 1'b1) begin n_fails++; $display("[TB] FAIL w1_%0d done: got busy=%b done=%b expected 0/1", i, busy1, done1); end
            n_checks++; if (sum1 !== es[i]) begin n_fails++; $display("[TB] FAIL w1_%0d sum: got %b expected %b", i, sum1, es[i]); end
            n_checks++; if (cout1 !== ec[i]) begin n_fails++; $display("[TB] FAIL w1_%0d cout: got %b expected %b", i, cout1, ec[i]); end
            @(negedge clk);
            n_checks++; if (done1 !== 1'b0) begin n_fails++; $display("[TB] FAIL w1_%0d pulse_end: got %b expected 0", i, done1); end
        end
    endtask

    initial begin
        $display("[TB] serial_add_ctrl bench starting");
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_mid_op();
        test_width1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
